// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: requester-side and sequencer-side signals of the ALU request arbiter
interface alu_req_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [3*N_REQ-1:0]      req_op;
    logic [DATA_W*N_REQ-1:0] req_a;
    logic [DATA_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       resp_data;
    logic                    resp_zero;
    logic                    resp_carry;
    logic                    resp_err;
    logic                    seq_start;
    logic [2:0]              seq_op;
    logic [DATA_W-1:0]       seq_a;
    logic [DATA_W-1:0]       seq_b;
    logic                    seq_busy;
    logic                    seq_result_valid;
    logic [DATA_W-1:0]       seq_result;
    logic                    seq_zero;
    logic                    seq_carry;

    modport slave (
        input  req, req_op, req_a, req_b, seq_busy, seq_result_valid, seq_result, seq_zero, seq_carry,
        output grant, done, resp_data, resp_zero, resp_carry, resp_err, seq_start, seq_op, seq_a, seq_b
    );

    modport master (
        output req, req_op, req_a, req_b, seq_busy, seq_result_valid, seq_result, seq_zero, seq_carry,
        input  grant, done, resp_data, resp_zero, resp_carry, resp_err, seq_start, seq_op, seq_a, seq_b
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one ALU sequencer between N_REQ requesters, with timeout abort
module alu_req_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    alu_req_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [IW-1:0]     last_q, win_q, win_d, idx;
    logic [CW-1:0]     cnt_q;
    logic [N_REQ-1:0]  grant_q, done_q;
    logic              seq_start_q, resp_zero_q, resp_carry_q, resp_err_q;
    logic [2:0]        seq_op_q;
    logic [DATA_W-1:0] seq_a_q, seq_b_q, resp_data_q;
    logic              timeout_d;

    // Scan from farthest to nearest so the first requester after last_q overrides the rest
    always_comb begin
        win_d = last_q;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_q) + k) % N_REQ);
            win_d = bus.req[idx] ? idx : win_d;
        end
    end

    assign timeout_d = (cnt_q + CW'(1)) == CW'(TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= IW'(N_REQ - 1);
            win_q        <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            seq_start_q  <= 1'b0;
            seq_op_q     <= '0;
            seq_a_q      <= '0;
            seq_b_q      <= '0;
            resp_data_q  <= '0;
            resp_zero_q  <= 1'b0;
            resp_carry_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|bus.req && !bus.seq_busy) begin
                    state_q     <= ISSUE;
                    win_q       <= win_d;
                    grant_q     <= N_REQ'(1) << win_d;
                    seq_op_q    <= bus.req_op[3*int'(win_d) +: 3];
                    seq_a_q     <= bus.req_a[DATA_W*int'(win_d) +: DATA_W];
                    seq_b_q     <= bus.req_b[DATA_W*int'(win_d) +: DATA_W];
                    seq_start_q <= 1'b1;
                end
                ISSUE: begin
                    state_q     <= WAIT;
                    seq_start_q <= 1'b0;
                    cnt_q       <= '0;
                end
                // A result arriving on the timeout cycle still wins over the abort
                WAIT: if (bus.seq_result_valid || timeout_d) begin
                    state_q      <= RESP;
                    done_q       <= grant_q;
                    resp_data_q  <= bus.seq_result_valid ? bus.seq_result : '0;
                    resp_zero_q  <= bus.seq_result_valid && bus.seq_zero;
                    resp_carry_q <= bus.seq_result_valid && bus.seq_carry;
                    resp_err_q   <= !bus.seq_result_valid;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                RESP: begin
                    state_q      <= IDLE;
                    last_q       <= win_q;
                    grant_q      <= '0;
                    done_q       <= '0;
                    resp_data_q  <= '0;
                    resp_zero_q  <= 1'b0;
                    resp_carry_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_zero  = resp_zero_q;
    assign bus.resp_carry = resp_carry_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.seq_start  = seq_start_q;
    assign bus.seq_op     = seq_op_q;
    assign bus.seq_a      = seq_a_q;
    assign bus.seq_b      = seq_b_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed latency/arbitration/timeout/reset cases plus random traffic,
// every cycle compared against a transaction-timeline model of the arbiter.
module tb_alu_req_arbiter;
    localparam int NR = 2;
    localparam int DW = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_req_arbiter_if #(.N_REQ(NR), .DATA_W(DW)) bus ();
    alu_req_arbiter #(.N_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, passes = 0, cyc = 0;
    int seq_delay = 3;
    bit rand_mode = 1'b0;

    int m_owner = -1, m_last = NR - 1, t_issue = -100, t_done = -100;
    bit m_res = 1'b0;
    logic [2:0] m_op = '0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_data = '0;
    logic m_zero = 1'b0, m_carry = 1'b0, m_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        else passes++;
    endtask

    // Model: one transaction at a time; issue cycle, resolution and done cycle tracked as cycle numbers
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_last = NR - 1; m_res = 1'b0; t_issue = -100; t_done = -100;
            m_op = '0; m_a = '0; m_b = '0;
        end else if (m_owner >= 0) begin
            if (!m_res && cyc > t_issue) begin
                if (bus.seq_result_valid || cyc == t_issue + TO) begin
                    m_res = 1'b1; t_done = cyc + 1; m_err = !bus.seq_result_valid;
                    m_data  = bus.seq_result_valid ? bus.seq_result : '0;
                    m_zero  = bus.seq_result_valid && bus.seq_zero;
                    m_carry = bus.seq_result_valid && bus.seq_carry;
                end
            end else if (m_res && cyc == t_done) begin
                m_last = m_owner; m_owner = -1;
            end
        end else if (bus.req != '0 && !bus.seq_busy) begin
            for (int k = 1; k <= NR; k++)
                if (m_owner < 0 && bus.req[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
            t_issue = cyc + 1; m_res = 1'b0;
            m_op = bus.req_op[3*m_owner +: 3];
            m_a  = bus.req_a[DW*m_owner +: DW];
            m_b  = bus.req_b[DW*m_owner +: DW];
        end
        cyc++;
    end

    initial forever begin
        logic [NR-1:0] exp_g;
        bit is_done;
        @(negedge clk);
        if (!rst) begin
            exp_g = m_owner >= 0 ? NR'(1) << m_owner : '0;
            is_done = m_owner >= 0 && m_res && cyc == t_done;
            chk("grant", bus.grant, exp_g);
            chk("seq_start", bus.seq_start, m_owner >= 0 && cyc == t_issue);
            chk("done", bus.done, is_done ? exp_g : '0);
            chk("seq_op", bus.seq_op, m_op);
            chk("seq_a", bus.seq_a, m_a);
            chk("seq_b", bus.seq_b, m_b);
            if (is_done) begin
                chk("resp_data", bus.resp_data, m_data);
                chk("resp_zero", bus.resp_zero, m_zero);
                chk("resp_carry", bus.resp_carry, m_carry);
                chk("resp_err", bus.resp_err, m_err);
            end
        end
    end

    function automatic int pick_delay();
        int r = $urandom_range(0, 9);
        return r < 6 ? r + 1 : r == 6 ? 14 : r == 7 ? 15 : r == 8 ? 16 : 40;
    endfunction

    // Sequencer stand-in: adds the latched operands and strobes the result a set delay after start
    initial begin
        int target = -1;
        logic [DW:0] sum;
        bus.seq_result_valid = 1'b0; bus.seq_result = '0; bus.seq_zero = 1'b0; bus.seq_carry = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                target = -1; bus.seq_result_valid = 1'b0;
            end else begin
                if (bus.seq_start) target = cyc + (rand_mode ? pick_delay() : seq_delay);
                sum = {1'b0, bus.seq_a} + {1'b0, bus.seq_b};
                bus.seq_result_valid = (cyc == target) || (rand_mode && $urandom_range(0, 15) == 0);
                bus.seq_result = sum[DW-1:0];
                bus.seq_zero = sum[DW-1:0] == '0;
                bus.seq_carry = sum[DW];
            end
        end
    end

    task automatic wait_start(output int at);
        at = -1;
        for (int n = 0; n < 60 && at < 0; n++) begin
            @(negedge clk);
            if (bus.seq_start) at = cyc;
        end
        chk("start_seen", at >= 0, 1);
    endtask

    task automatic wait_done(output int at, output logic [NR-1:0] dv);
        at = -1; dv = '0;
        for (int n = 0; n < 60 && at < 0; n++) begin
            @(negedge clk);
            if (bus.done != '0) begin at = cyc; dv = bus.done; end
        end
        chk("done_seen", at >= 0, 1);
    endtask

    initial begin
        int s, d;
        logic [NR-1:0] dv;
        rst = 1'b1;
        bus.req = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.seq_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_start", bus.seq_start, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        @(negedge clk);
        bus.req = 2'b01; bus.req_op[2:0] = 3'd0; bus.req_a[7:0] = 8'h05; bus.req_b[7:0] = 8'h03;
        @(negedge clk);
        chk("t1_start", bus.seq_start, 1);
        chk("t1_grant", bus.grant, 2'b01);
        s = cyc;
        wait_done(d, dv);
        bus.req = '0;
        chk("t1_latency", d - s, 4);
        chk("t1_done", dv, 2'b01);
        chk("t1_data", bus.resp_data, 8'h08);
        chk("t1_err", bus.resp_err, 0);
        @(negedge clk);
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_start(s);
            chk("rr_grant", bus.grant, k % 2 == 0 ? 2'b10 : 2'b01);
            wait_done(d, dv);
            chk("rr_done", dv, k % 2 == 0 ? 2'b10 : 2'b01);
            if (k == 3) bus.req = '0;
        end
        @(negedge clk);
        bus.seq_busy = 1'b1; bus.req = 2'b10;
        repeat (5) begin
            @(negedge clk);
            chk("busy_grant", bus.grant, 0);
            chk("busy_start", bus.seq_start, 0);
        end
        bus.seq_busy = 1'b0;
        @(negedge clk);
        chk("unbusy_grant", bus.grant, 2'b10);
        chk("unbusy_start", bus.seq_start, 1);
        wait_done(d, dv);
        bus.req = '0;
        @(negedge clk);
        seq_delay = 99; bus.req = 2'b01; bus.req_a[7:0] = 8'h01; bus.req_b[7:0] = 8'h02;
        wait_start(s);
        bus.req = '0;
        wait_done(d, dv);
        chk("to_latency", d - s, TO + 1);
        chk("to_done", dv, 2'b01);
        chk("to_err", bus.resp_err, 1);
        chk("to_data", bus.resp_data, 0);
        @(negedge clk);
        seq_delay = TO; bus.req = 2'b10; bus.req_a[15:8] = 8'hF0; bus.req_b[15:8] = 8'h20;
        wait_start(s);
        bus.req = '0;
        wait_done(d, dv);
        chk("edge_latency", d - s, TO + 1);
        chk("edge_err", bus.resp_err, 0);
        chk("edge_data", bus.resp_data, 8'h10);
        chk("edge_carry", bus.resp_carry, 1);
        @(negedge clk);
        seq_delay = 99; bus.req = 2'b01; bus.req_op[2:0] = 3'd5; bus.req_a[7:0] = 8'hAA; bus.req_b[7:0] = 8'h55;
        wait_start(s);
        bus.req = '0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", bus.grant, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_start", bus.seq_start, 0);
        chk("arst_op", bus.seq_op, 0);
        chk("arst_a", bus.seq_a, 0);
        chk("arst_b", bus.seq_b, 0);
        chk("arst_err", bus.resp_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; seq_delay = 3; bus.req = 2'b11;
        wait_start(s);
        chk("arst_first", bus.grant, 2'b01);
        wait_done(d, dv);
        bus.req = '0;
        rand_mode = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            bus.seq_busy = $urandom_range(0, 3) == 0;
            for (int i = 0; i < NR; i++) begin
                int r = $urandom_range(0, 15);
                if (!bus.req[i] && r < 4) bus.req[i] = 1'b1;
                else if (bus.req[i] && r == 0) bus.req[i] = 1'b0;
                if (r < 6) begin
                    bus.req_op[3*i +: 3] = 3'($urandom);
                    bus.req_a[DW*i +: DW] = DW'($urandom);
                    bus.req_b[DW*i +: DW] = DW'($urandom);
                end
            end
        end
        bus.req = '0; bus.seq_busy = 1'b0;
        repeat (60) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
